// File: rtl/dds_pkg.sv
// Shared constants, state encoding and clamp helpers for the DDS sweep.
// DDS_SWEEP_TRIANGLE_EN adds the down-ramp helper and the low-bound field.
package dds_pkg;

  localparam int KW_WIDTH    = 12;
  localparam int DWELL_WIDTH = 24;

  localparam logic [KW_WIDTH-1:0] KW_RESET = KW_WIDTH'(5);

  typedef logic [KW_WIDTH-1:0] kw_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_STEP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
`ifdef DDS_SWEEP_TRIANGLE_EN
    kw_t lo;
`endif
    kw_t hi;
    kw_t step;
  } cfg_t;

  // Extra carry bit so a wrap past all-ones still clamps to hi.
  function automatic kw_t clamp_up(
    input kw_t kw,
    input kw_t step,
    input kw_t hi
  );
    logic [KW_WIDTH:0] s;
    s = {1'b0, kw} + {1'b0, step};
    return (s > {1'b0, hi}) ? hi : s[KW_WIDTH-1:0];
  endfunction

`ifdef DDS_SWEEP_TRIANGLE_EN
  function automatic kw_t clamp_dn(
    input kw_t kw,
    input kw_t step,
    input kw_t lo
  );
    logic [KW_WIDTH:0] d;
    d = {1'b0, kw} - {1'b0, step};
    if (d[KW_WIDTH] || (d[KW_WIDTH-1:0] < lo))
      return lo;
    return d[KW_WIDTH-1:0];
  endfunction
`endif

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell counter: loadable period, clear, and a terminal count that
// fires one cycle early so the step cycle lands inside the period.
module dds_dwell_timer
  import dds_pkg::*;
(
  input  logic                   CLK,
  input  logic                   Rstn,
  input  logic                   Load,
  input  logic [DWELL_WIDTH-1:0] Period,
  input  logic                   Clr,
  input  logic                   En,
  output logic                   Tc,
  output logic                   Short
);

  logic [DWELL_WIDTH-1:0] per_q;
  logic [DWELL_WIDTH-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!Rstn) begin
      per_q <= '0;
      cnt_q <= '0;
    end else begin
      if (Load)
        per_q <= Period;
      if (Clr)
        cnt_q <= '0;
      else if (En)
        cnt_q <= cnt_q + DWELL_WIDTH'(1);
    end
  end

  assign Short = (per_q[DWELL_WIDTH-1:1] == '0);
  assign Tc    = (cnt_q == per_q - DWELL_WIDTH'(2));

endmodule

// File: rtl/dds_sweep_controller.sv
// Timed linear KW sweep for the DDS accumulator, all outputs registered.
// DDS_SWEEP_TRIANGLE_EN: bounce between Min and Max until stopped.
module dds_sweep_controller
  import dds_pkg::*;
(
  input  logic                   CLK,
  input  logic                   Rstn,
  input  logic                   Start_Sig,
  input  logic                   Stop_Sig,
  input  logic [KW_WIDTH-1:0]    KW_Min,
  input  logic [KW_WIDTH-1:0]    KW_Max,
  input  logic [KW_WIDTH-1:0]    KW_Step,
  input  logic [DWELL_WIDTH-1:0] Dwell,
  output logic [KW_WIDTH-1:0]    KW,
  output logic                   KW_Update,
  output logic                   Busy,
  output logic                   Done_Sig,
  output logic                   Err_Sig
);

  state_t state_q, state_d;
  cfg_t   cfg_q, cfg_d;
  kw_t    kw_d;
  logic   upd_d, busy_d, done_d, err_d;
  logic   t_load, t_clr, t_en, t_tc, t_short;
  logic   start_ok, short_in;

  assign start_ok = (KW_Min <= KW_Max) && (KW_Step != '0);
  assign short_in = (Dwell[DWELL_WIDTH-1:1] == '0);

`ifdef DDS_SWEEP_TRIANGLE_EN
  logic dir_q, dir_d, up_dir;

  assign up_dir = dir_q ? (KW != cfg_q.hi)
                        : (KW == cfg_q.lo);
`endif

  dds_dwell_timer u_timer (
    .CLK    (CLK),
    .Rstn   (Rstn),
    .Load   (t_load),
    .Period (Dwell),
    .Clr    (t_clr),
    .En     (t_en),
    .Tc     (t_tc),
    .Short  (t_short)
  );

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    kw_d    = KW;
    upd_d   = 1'b0;
    busy_d  = Busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    t_load  = 1'b0;
    t_clr   = 1'b0;
    t_en    = 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
    dir_d   = dir_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (Start_Sig && !Stop_Sig) begin
          if (start_ok) begin
            cfg_d.hi   = KW_Max;
            cfg_d.step = KW_Step;
`ifdef DDS_SWEEP_TRIANGLE_EN
            cfg_d.lo   = KW_Min;
            dir_d      = 1'b1;
`endif
            kw_d    = KW_Min;
            upd_d   = 1'b1;
            busy_d  = 1'b1;
            t_load  = 1'b1;
            t_clr   = 1'b1;
            state_d = short_in ? ST_STEP : ST_DWELL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DWELL: begin
        if (Stop_Sig) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          t_en = 1'b1;
          if (t_tc)
            state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (Stop_Sig) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          t_clr   = 1'b1;
          state_d = t_short ? ST_STEP : ST_DWELL;
`ifdef DDS_SWEEP_TRIANGLE_EN
          if (cfg_q.lo != cfg_q.hi) begin
            kw_d  = up_dir
                  ? clamp_up(KW, cfg_q.step, cfg_q.hi)
                  : clamp_dn(KW, cfg_q.step, cfg_q.lo);
            upd_d = 1'b1;
            dir_d = up_dir;
          end
`else
          if (KW == cfg_q.hi) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            kw_d  = clamp_up(KW, cfg_q.step, cfg_q.hi);
            upd_d = 1'b1;
          end
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Rstn) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      KW        <= KW_RESET;
      KW_Update <= 1'b0;
      Busy      <= 1'b0;
      Done_Sig  <= 1'b0;
      Err_Sig   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      KW        <= kw_d;
      KW_Update <= upd_d;
      Busy      <= busy_d;
      Done_Sig  <= done_d;
      Err_Sig   <= err_d;
    end
  end

`ifdef DDS_SWEEP_TRIANGLE_EN
  always_ff @(posedge CLK) begin
    if (!Rstn)
      dir_q <= 1'b1;
    else
      dir_q <= dir_d;
  end
`endif

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Directed bench for dds_sweep_controller; expected values hand-derived.
// Define DDS_SWEEP_TRIANGLE_EN to exercise the triangle build instead.
module tb_dds_sweep_controller;

  logic        CLK = 1'b0;
  logic        Rstn = 1'b0;
  logic        Start_Sig = 1'b0;
  logic        Stop_Sig = 1'b0;
  logic [11:0] KW_Min = '0;
  logic [11:0] KW_Max = '0;
  logic [11:0] KW_Step = '0;
  logic [23:0] Dwell = '0;
  logic [11:0] KW;
  logic        KW_Update, Busy, Done_Sig, Err_Sig;

  int n_run = 0;
  int n_fail = 0;

  int uc[$];
  int uk[$];
  int done_c, done_n, fall_c, err_n;

  always #5 CLK = ~CLK;

  dds_sweep_controller dut (
    .CLK       (CLK),
    .Rstn      (Rstn),
    .Start_Sig (Start_Sig),
    .Stop_Sig  (Stop_Sig),
    .KW_Min    (KW_Min),
    .KW_Max    (KW_Max),
    .KW_Step   (KW_Step),
    .Dwell     (Dwell),
    .KW        (KW),
    .KW_Update (KW_Update),
    .Busy      (Busy),
    .Done_Sig  (Done_Sig),
    .Err_Sig   (Err_Sig)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d",
               tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input int mn, input int mx,
                       input int st, input int dw);
    KW_Min    = 12'(mn);
    KW_Max    = 12'(mx);
    KW_Step   = 12'(st);
    Dwell     = 24'(dw);
    Start_Sig = 1'b1;
    tick();
    Start_Sig = 1'b0;
  endtask

  task automatic watch(input int n);
    uc.delete();
    uk.delete();
    done_c = -1;
    done_n = 0;
    fall_c = -1;
    err_n  = 0;
    for (int c = 0; c < n; c++) begin
      if (KW_Update) begin
        uc.push_back(c);
        uk.push_back(int'(KW));
      end
      if (Done_Sig) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (!Busy && fall_c < 0) fall_c = c;
      if (Err_Sig) err_n++;
      tick();
    end
  endtask

  task automatic chk_upd(input string tag, input int i,
                         input int c, input int k);
    if (i < uc.size()) begin
      chk({tag, "_cyc"}, uc[i], c);
      chk({tag, "_kw"}, uk[i], k);
    end else begin
      chk({tag, "_missing"}, uc.size(), i + 1);
    end
  endtask

  task automatic wait_kw(input string tag, input int v,
                         input int lim);
    for (int i = 0; i < lim && int'(KW) != v; i++)
      tick();
    chk(tag, KW, v);
  endtask

`ifdef DDS_SWEEP_TRIANGLE_EN
  int tri_seq[4] = '{1, 3, 5, 3};
`endif

  initial begin
    tick();
    tick();
    chk("rst_kw", KW, 5);
    chk("rst_busy", Busy, 0);
    Rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk("idle", {KW, Busy, KW_Update, Done_Sig, Err_Sig},
          {12'd5, 4'b0000});
      tick();
    end

`ifdef DDS_SWEEP_TRIANGLE_EN
    start(1, 5, 2, 1);
    done_n = 0;
    for (int c = 0; c < 30; c++) begin
      chk("tri_kw", KW, tri_seq[c % 4]);
      chk("tri_upd", KW_Update, 1);
      if (Done_Sig) done_n++;
      tick();
    end
    chk("tri_no_done", done_n, 0);
    chk("tri_busy", Busy, 1);
    Stop_Sig = 1'b1;
    tick();
    Stop_Sig = 1'b0;
    chk("tri_stop_busy", Busy, 0);

    start(9, 9, 1, 2);
    watch(12);
    chk("tri_eq_n", uc.size(), 1);
    chk_upd("tri_eq0", 0, 0, 9);
    chk("tri_eq_done", done_n, 0);
    chk("tri_eq_kw", KW, 9);
    Stop_Sig = 1'b1;
    tick();
    Stop_Sig = 1'b0;
`else
    start(2, 10, 3, 4);
    watch(20);
    chk("sw_n", uc.size(), 4);
    chk_upd("sw0", 0, 0, 2);
    chk_upd("sw1", 1, 4, 5);
    chk_upd("sw2", 2, 8, 8);
    chk_upd("sw3", 3, 12, 10);
    chk("sw_done_c", done_c, 16);
    chk("sw_done_n", done_n, 1);
    chk("sw_busy_fall", fall_c, 16);
    chk("sw_kw_end", KW, 10);

    start(4090, 4095, 8, 4);
    watch(12);
    chk("cy_n", uc.size(), 2);
    chk_upd("cy0", 0, 0, 4090);
    chk_upd("cy1", 1, 4, 4095);
    chk("cy_done_c", done_c, 8);

    start(7, 3, 1, 4);
    chk("bad_err", Err_Sig, 1);
    chk("bad_kw", KW, 4095);
    chk("bad_busy", Busy, 0);
    chk("bad_upd", KW_Update, 0);
    tick();
    chk("bad_err_end", Err_Sig, 0);
    start(1, 9, 0, 4);
    chk("step0_err", Err_Sig, 1);
    tick();

    start(1, 5, 2, 1);
    watch(6);
    chk("d1_n", uc.size(), 3);
    chk_upd("d1_0", 0, 0, 1);
    chk_upd("d1_1", 1, 1, 3);
    chk_upd("d1_2", 2, 2, 5);
    chk("d1_done_c", done_c, 3);

    start(1, 5, 2, 0);
    watch(6);
    chk("d0_n", uc.size(), 3);
    chk("d0_done_c", done_c, 3);

    start(9, 9, 1, 3);
    watch(8);
    chk("eq_n", uc.size(), 1);
    chk_upd("eq0", 0, 0, 9);
    chk("eq_done_c", done_c, 3);
`endif

    start(0, 100, 1, 2);
    wait_kw("stop_reach", 37, 200);
    Stop_Sig = 1'b1;
    tick();
    Stop_Sig = 1'b0;
    chk("stop_busy", Busy, 0);
    chk("stop_kw", KW, 37);
    chk("stop_upd", KW_Update, 0);
    watch(10);
    chk("stop_quiet", uc.size(), 0);
    chk("stop_no_done", done_n, 0);
    chk("stop_kw_hold", KW, 37);

    start(0, 100, 1, 2);
    wait_kw("ss_reach", 20, 100);
    Start_Sig = 1'b1;
    Stop_Sig  = 1'b1;
    tick();
    Start_Sig = 1'b0;
    Stop_Sig  = 1'b0;
    chk("ss_busy", Busy, 0);
    chk("ss_kw", KW, 20);
    chk("ss_err", Err_Sig, 0);
    watch(6);
    chk("ss_quiet", uc.size(), 0);

    start(0, 100, 1, 2);
    wait_kw("rs_reach10", 10, 100);
    KW_Min    = 12'd90;
    KW_Max    = 12'd95;
    KW_Step   = 12'd5;
    Start_Sig = 1'b1;
    tick();
    Start_Sig = 1'b0;
    chk("busy_start_err", Err_Sig, 0);
    chk("busy_start_kw", KW, 10);
    chk("busy_start_busy", Busy, 1);
    tick();
    chk("busy_next_upd", KW_Update, 1);
    chk("busy_next_kw", KW, 11);
    wait_kw("rs_reach50", 50, 200);
    Rstn = 1'b0;
    tick();
    Rstn = 1'b1;
    chk("rs_kw", KW, 5);
    chk("rs_busy", Busy, 0);
    chk("rs_upd", KW_Update, 0);
    watch(5);
    chk("rs_quiet", uc.size(), 0);
    chk("rs_no_done", done_n, 0);
    chk("rs_kw_hold", KW, 5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
